// File: rtl/aes_192_req_arbiter_pkg.sv
// Shared types for the AES-192 request arbiter: FSM state encoding and defaults.
package aes_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB_IDLE,
    ST_ARB_ISSUE,
    ST_ARB_WAIT,
    ST_ARB_RESP
  } AES_ARB_STATE_TYPE;

  localparam int AES_ARB_TIMEOUT_DEFAULT = 255;
  localparam int AES_ARB_STATE_W         = 128;
  localparam int AES_ARB_KEY_W           = 192;

  // Index width for a requester count; never below one bit.
  function automatic int arb_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aes_192_req_arbiter_if.sv
// Requester-side and core-side signals of the AES-192 arbiter; slave = arbiter, master = environment.
interface aes_192_req_arbiter_if
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = arb_idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ*AES_ARB_STATE_W-1:0] req_state;
  logic [NUM_REQ*AES_ARB_KEY_W-1:0]   req_key;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0]                 rsp_ready;
  logic [AES_ARB_STATE_W-1:0]         rsp_data;
  logic                               rsp_err;
  logic                               aes_start;
  logic [AES_ARB_STATE_W-1:0]         aes_state;
  logic [AES_ARB_KEY_W-1:0]           aes_key;
  logic [AES_ARB_STATE_W-1:0]         aes_out;
  logic                               aes_out_valid;
  logic                               key_complete;
  logic                               busy;
  logic [IDX_W-1:0]                   grant_id;

  modport slave (
    input  req_valid, req_state, req_key, rsp_ready, aes_out, aes_out_valid, key_complete,
    output req_ready, rsp_valid, rsp_data, rsp_err, aes_start, aes_state, aes_key, busy, grant_id
  );

  modport master (
    output req_valid, req_state, req_key, rsp_ready, aes_out, aes_out_valid, key_complete,
    input  req_ready, rsp_valid, rsp_data, rsp_err, aes_start, aes_state, aes_key, busy, grant_id
  );

endinterface

// File: rtl/aes_192_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_any
);

  int w_j;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!o_any && i_req[w_j]) begin
        o_any          = 1'b1;
        o_gnt[w_j]     = 1'b1;
        o_gnt_idx      = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/aes_192_req_arbiter.sv
// Shares one AES-192 core between NUM_REQ requesters, one operation in flight.
// Optional WAIT watchdog enabled by defining AES_ARB_TIMEOUT_EN.
//
// state        | meaning
// ST_ARB_IDLE  | waiting for key_complete and a request; grant is combinational
// ST_ARB_ISSUE | one-cycle aes_start with latched state/key
// ST_ARB_WAIT  | waiting for aes_out_valid; key drop marks result bad
// ST_ARB_RESP  | result held to the grantee until its rsp_ready
module aes_192_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = AES_ARB_TIMEOUT_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_192_req_arbiter_if.slave bus
);

  localparam int IDX_W = arb_idx_w(NUM_REQ);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("aes_192_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  AES_ARB_STATE_TYPE r_st, w_st_nxt;

  logic [IDX_W-1:0]           r_rr_ptr;
  logic [IDX_W-1:0]           r_grant_id;
  logic [AES_ARB_STATE_W-1:0] r_aes_state;
  logic [AES_ARB_KEY_W-1:0]   r_aes_key;
  logic [AES_ARB_STATE_W-1:0] r_rsp_data;
  logic                       r_rsp_err;
  logic                       r_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_any;
  logic               w_take;
  logic               w_rsp_done;
  logic               w_err_now;
  logic               w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req     (bus.req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_take     = (r_st == ST_ARB_IDLE) && bus.key_complete && w_any;
  assign w_rsp_done = (r_st == ST_ARB_RESP) && bus.rsp_ready[r_grant_id];
  // A key drop in the same cycle as the result strobe still spoils it.
  assign w_err_now  = r_err | ~bus.key_complete;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_wd_cnt <= '0;
    else if (r_st == ST_ARB_ISSUE) r_wd_cnt <= '0;
    else if (r_st == ST_ARB_WAIT)  r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  assign w_timeout = (r_st == ST_ARB_WAIT) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ST_ARB_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_ARB_IDLE:  if (w_take) w_st_nxt = ST_ARB_ISSUE;
      ST_ARB_ISSUE: w_st_nxt = ST_ARB_WAIT;
      ST_ARB_WAIT:  if (bus.aes_out_valid || w_timeout) w_st_nxt = ST_ARB_RESP;
      ST_ARB_RESP:  if (w_rsp_done) w_st_nxt = ST_ARB_IDLE;
      default:      w_st_nxt = ST_ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = w_take ? w_gnt : '0;
    bus.aes_start = (r_st == ST_ARB_ISSUE);
    bus.busy      = (r_st != ST_ARB_IDLE);
    bus.rsp_valid = '0;
    if (r_st == ST_ARB_RESP) bus.rsp_valid[r_grant_id] = 1'b1;
  end

  assign bus.aes_state = r_aes_state;
  assign bus.aes_key   = r_aes_key;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.grant_id  = r_grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_aes_state <= '0;
      r_aes_key   <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_take) begin
        r_aes_state <= bus.req_state[w_gnt_idx*AES_ARB_STATE_W +: AES_ARB_STATE_W];
        r_aes_key   <= bus.req_key[w_gnt_idx*AES_ARB_KEY_W +: AES_ARB_KEY_W];
        r_grant_id  <= w_gnt_idx;
      end
      if (r_st == ST_ARB_WAIT) begin
        if (!bus.key_complete) r_err <= 1'b1;
        if (bus.aes_out_valid) begin
          r_rsp_err  <= w_err_now;
          r_rsp_data <= w_err_now ? '0 : bus.aes_out;
        end else if (w_timeout) begin
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
        end
      end
      if (w_rsp_done) begin
        r_rr_ptr <= (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        r_err    <= 1'b0;
      end
    end
  end

endmodule
